// File: rtl/tluh_master_port.sv
// TL-UH initiator: single-beat req/rsp to A/D channels; req->A and D->rsp each take one cycle; TLUH_MASTER_ATOMIC_EN adds atomics.
// Backpressure: req_ready_o needs a free A slot, a free source ID and headroom under MAX; D stalls while the response register is held.
module tluh_master_port #(
    parameter int          AW  = 32,
    parameter int          RS  = 4,
    parameter logic [RS:0] MAX = 2
) (
    input  logic          master_clock_i,
    input  logic          master_reset_i,
`ifdef TLUH_MASTER_ATOMIC_EN
    input  logic          req_atomic_i,
    input  logic [3:0]    req_amo_param_i,
`endif
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_write_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [3:0]    req_size_i,
    input  logic [3:0]    req_mask_i,
    input  logic [31:0]   req_data_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_data_o,
    output logic [RS-1:0] rsp_source_o,
    output logic          rsp_write_o,
    output logic          rsp_denied_o,
    output logic          rsp_corrupt_o,
    output logic [2:0]    master_a_opcode,
    output logic [2:0]    master_a_param,
    output logic [3:0]    master_a_size,
    output logic [RS-1:0] master_a_source,
    output logic [AW-1:0] master_a_address,
    output logic [3:0]    master_a_mask,
    output logic [31:0]   master_a_data,
    output logic          master_a_corrupt,
    output logic          master_a_valid,
    input  logic          master_a_ready,
    input  logic [2:0]    master_d_opcode,
    input  logic [1:0]    master_d_param,
    input  logic [3:0]    master_d_size,
    input  logic [RS-1:0] master_d_source,
    input  logic          master_d_denied,
    input  logic [31:0]   master_d_data,
    input  logic          master_d_corrupt,
    input  logic          master_d_valid,
    output logic          master_d_ready,
    output logic [RS:0]   outstanding_o,
    output logic          err_o
);

    localparam int NID = 1 << RS;

    typedef struct packed {
        logic [2:0]    opcode;
        logic [2:0]    param;
        logic [3:0]    size;
        logic [RS-1:0] source;
        logic [AW-1:0] address;
        logic [3:0]    mask;
        logic [31:0]   data;
    } a_req_t;

    a_req_t          r_a;
    logic            r_a_vld;
    logic [RS:0]     r_outstanding;
    logic [NID-1:0]  r_inflight;
    logic [NID-1:0]  r_type_wr;
    logic            r_rsp_vld;
    logic [31:0]     r_rsp_data;
    logic [RS-1:0]   r_rsp_source;
    logic            r_rsp_write;
    logic            r_rsp_denied;
    logic            r_rsp_corrupt;
    logic            r_err;

    a_req_t          w_a_nxt;
    logic            w_is_write;
    logic [3:0]      w_size_mask;
    logic            w_free_vld;
    logic [RS-1:0]   w_free_id;
    logic [RS:0]     w_busy;
    logic            w_req_rdy;
    logic            w_req_hs;
    logic            w_a_hs;
    logic            w_d_hs;
    logic [NID-1:0]  w_set_vec;
    logic [NID-1:0]  w_clr_vec;
    logic [2:0]      w_d_exp_op;
    logic            w_d_err;
    logic            w_unused;

    assign w_unused = ^{master_d_param, master_d_size};

    // Lowest clear inflight bit wins.
    always_comb begin
        w_free_vld = 1'b0;
        w_free_id  = '0;
        for (int i = NID - 1; i >= 0; i--) begin
            if (!r_inflight[i]) begin
                w_free_vld = 1'b1;
                w_free_id  = RS'(i);
            end
        end
    end

    // A-slot occupant counts against MAX whether or not it handshakes this cycle.
    assign w_busy    = r_outstanding + {{RS{1'b0}}, r_a_vld};
    assign w_req_rdy = (!r_a_vld || master_a_ready) && w_free_vld && (w_busy < MAX);
    assign w_req_hs  = req_valid_i && w_req_rdy;
    assign w_a_hs    = r_a_vld && master_a_ready;
    assign w_d_hs    = master_d_valid && master_d_ready;

    always_comb begin
        case (req_size_i)
            4'd0:    w_size_mask = 4'b0001 << req_addr_i[1:0];
            4'd1:    w_size_mask = req_addr_i[1] ? 4'b1100 : 4'b0011;
            default: w_size_mask = 4'b1111;
        endcase
    end

    always_comb begin
        w_a_nxt         = '0;
        w_a_nxt.size    = req_size_i;
        w_a_nxt.source  = w_free_id;
        w_a_nxt.address = req_addr_i;
        w_is_write      = req_write_i;
        if (req_write_i) begin
            w_a_nxt.mask   = req_mask_i & w_size_mask;
            w_a_nxt.opcode = ((req_mask_i & w_size_mask) == w_size_mask) ? 3'd0 : 3'd1;
            w_a_nxt.data   = req_data_i;
        end else begin
            w_a_nxt.mask   = w_size_mask;
            w_a_nxt.opcode = 3'd4;
        end
`ifdef TLUH_MASTER_ATOMIC_EN
        // Atomics return data, so they are recorded as reads for the D type check.
        if (req_atomic_i) begin
            w_a_nxt.opcode = req_amo_param_i[3] ? 3'd3 : 3'd2;
            w_a_nxt.param  = req_amo_param_i[2:0];
            w_a_nxt.mask   = w_size_mask;
            w_a_nxt.data   = req_data_i;
            w_is_write     = 1'b0;
        end
`endif
    end

    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        for (int i = 0; i < NID; i++) begin
            w_set_vec[i] = w_req_hs && (w_free_id == RS'(i));
            w_clr_vec[i] = w_d_hs && (master_d_source == RS'(i));
        end
    end

    assign w_d_exp_op = r_type_wr[master_d_source] ? 3'd0 : 3'd1;
    assign w_d_err    = w_d_hs && (!r_inflight[master_d_source] ||
                                   (master_d_opcode != w_d_exp_op) ||
                                   (r_outstanding == '0));

    always_ff @(posedge master_clock_i or posedge master_reset_i) begin
        if (master_reset_i) begin
            r_a           <= '0;
            r_a_vld       <= 1'b0;
            r_outstanding <= '0;
            r_inflight    <= '0;
            r_type_wr     <= '0;
            r_rsp_vld     <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_source  <= '0;
            r_rsp_write   <= 1'b0;
            r_rsp_denied  <= 1'b0;
            r_rsp_corrupt <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_a_vld              <= 1'b1;
                r_a                  <= w_a_nxt;
                r_type_wr[w_free_id] <= w_is_write;
            end else if (w_a_hs) begin
                r_a_vld <= 1'b0;
            end

            // A stray D with nothing outstanding must not wrap the counter.
            case ({w_a_hs, w_d_hs})
                2'b10:   r_outstanding <= r_outstanding + {{RS{1'b0}}, 1'b1};
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - {{RS{1'b0}}, 1'b1};
                default: ;
            endcase

            r_inflight <= (r_inflight & ~w_clr_vec) | w_set_vec;

            if (w_d_hs) begin
                r_rsp_vld     <= 1'b1;
                r_rsp_data    <= master_d_data;
                r_rsp_source  <= master_d_source;
                r_rsp_write   <= (master_d_opcode == 3'd0);
                r_rsp_denied  <= master_d_denied;
                r_rsp_corrupt <= master_d_corrupt;
            end else if (rsp_ready_i) begin
                r_rsp_vld <= 1'b0;
            end

            if (w_d_err) r_err <= 1'b1;
        end
    end

    assign req_ready_o      = w_req_rdy;
    assign master_d_ready   = !r_rsp_vld || rsp_ready_i;

    assign master_a_valid   = r_a_vld;
    assign master_a_opcode  = r_a.opcode;
    assign master_a_param   = r_a.param;
    assign master_a_size    = r_a.size;
    assign master_a_source  = r_a.source;
    assign master_a_address = r_a.address;
    assign master_a_mask    = r_a.mask;
    assign master_a_data    = r_a.data;
    assign master_a_corrupt = 1'b0;

    assign rsp_valid_o      = r_rsp_vld;
    assign rsp_data_o       = r_rsp_data;
    assign rsp_source_o     = r_rsp_source;
    assign rsp_write_o      = r_rsp_write;
    assign rsp_denied_o     = r_rsp_denied;
    assign rsp_corrupt_o    = r_rsp_corrupt;

    assign outstanding_o    = r_outstanding;
    assign err_o            = r_err;

endmodule

// File: doc/tluh_master_port.md
# tluh_master_port

TileLink-UH initiator port converting a simple single-beat request/response interface into A-channel requests and D-channel response collection. It is the master-side counterpart to our TL-UH slave blocks (SRAM and peripherals), owning source-ID allocation, outstanding-transaction accounting and A/D-channel stability. It sits between a CPU load/store unit or DMA engine and the crossbar.

## Interface
- AW, 32, address width
- RS, 4, source-ID width; ID pool is 2^RS
- MAX, 2, max outstanding transactions, [RS:0] wide; must satisfy 1 ≤ MAX ≤ 2^RS
- master_clock_i  in  1  clock
- master_reset_i  in  1  **asynchronous, active-high** reset
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  AW  byte address, naturally aligned to req_size_i (requester guarantees alignment)
- req_size_i  in  4  log2 bytes, 0..2 only
- req_mask_i  in  4  byte lanes
- req_data_i  in  32  write data
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake
- rsp_data_o  out  32  read data
- rsp_source_o  out  RS  source ID of the completed transaction
- rsp_write_o  out  1  1 = AccessAck, 0 = AccessAckData
- rsp_denied_o, rsp_corrupt_o  out  1  copied from D
- master_a_opcode/param/size/source/address/mask/data/corrupt/valid  out  3/3/4/RS/AW/4/32/1/1  TL A channel
- master_a_ready  in  1
- master_d_opcode/param/size/source/denied/data/corrupt/valid  in  3/2/4/RS/1/32/1/1  TL D channel
- master_d_ready  out  1
- outstanding_o  out  RS+1  transactions accepted on A and not yet retired on D
- err_o  out  1  sticky protocol-error flag

## Operation
- Opcode: read → Get (4), mask forced from size/address; write with mask covering the full size → PutFullData (0), otherwise PutPartialData (1). a_param = 0, a_corrupt = 0.
- Source allocator: `inflight` bitmap, 2^RS bits; on request acceptance picks the lowest clear bit.
- req_ready_o = (!a_valid_q || master_a_ready) && free ID exists && (outstanding_o + pending A) < MAX.
- A register: loaded on req handshake; holds every field stable while master_a_valid && !master_a_ready; clears on A handshake unless reloaded in the same cycle.
- outstanding_o: +1 on A handshake, −1 on D handshake, unchanged when both occur or neither occurs.
- `inflight` bit is set at allocation (request acceptance); it is cleared on D handshake.
- Response register: one entry. master_d_ready = !rsp_valid_o || rsp_ready_i. It loads from D on D handshake.
- err_o is set (sticky until reset) in three cases: D handshake with a source that is not in flight; D opcode ∉ {0,1}, or opcode mismatch versus the recorded write/read type; D handshake while outstanding_o == 0. In all three cases the response is still forwarded.
- Per-ID 1-bit type table records write/read for the mismatch check.

## Timing
- Reset (async assert, sync deassert usage): master_a_valid = 0, all A fields 0, rsp_valid_o = 0, rsp fields 0, outstanding_o = 0, inflight = 0, err_o = 0; req_ready_o follows its equation (1 after reset).
- Request handshake in cycle N → master_a_valid = 1 in cycle N+1. Back-to-back issue is possible when master_a_ready = 1.
- D handshake in cycle N → rsp_valid_o = 1 in cycle N+1. Full throughput when rsp_ready_i = 1.
- A freed ID becomes allocatable in the cycle after the D handshake, not the same cycle.
- Reset mid-transaction drops all state. Responses arriving after reset for pre-reset IDs set err_o.

## Configuration
- TLUH_MASTER_ATOMIC_EN defined: adds inputs req_atomic_i (1) and req_amo_param_i (4). When req_atomic_i = 1, bit 3 selects the opcode (0 → ArithmeticData 2, 1 → LogicalData 3) and bits 2:0 drive a_param. Size ≤ 2. The response is AccessAckData and is reported with rsp_write_o = 0.
- TLUH_MASTER_ATOMIC_EN undefined: the ports are absent, and opcodes 2/3 are never generated.

## Test plan
- Single read, addr 0x100, size 2: A carries opcode 4, mask 0xF, source 0. D AccessAckData with data 0xDEADBEEF → rsp_data_o = 0xDEADBEEF, outstanding_o returns 1 → 0.
- Write with size 2 and mask 0x3: opcode 1. Write with mask 0xF: opcode 0. Hold master_a_ready = 0 for 5 cycles → all A fields stable.
- MAX = 2: issue 3 reads with D stalled → req_ready_o = 0 after the 2nd, source IDs 0 then 1. Respond to ID 1 first → the 3rd request gets ID 1.
- A and D handshake in the same cycle → outstanding_o unchanged. Hold rsp_ready_i = 0 → master_d_ready = 0 with the response register full.
- D with source 3 that is not in flight → err_o = 1 and stays 1. Assert reset mid-burst → all outputs return to their reset values immediately.
- With TLUH_MASTER_ATOMIC_EN: atomic with param 4'b1010 → opcode 3, a_param 2. D AccessAckData → rsp_write_o = 0.
